// File: rtl/fp_add_align_pipe_if.sv
// Handshake and data bundle between the operand source, the alignment
// front end and the downstream add/normalise stage.
interface fp_add_align_pipe_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int FP_W   = 1 + EXP_W + MAN_W;
  localparam int FRAC_W = MAN_W + 4;

  // Operand side
  logic              in_valid;
  logic              in_ready;
  logic [FP_W-1:0]   op_a;
  logic [FP_W-1:0]   op_b;
  logic              op_sub;

  // Result side
  logic              out_valid;
  logic              out_ready;
  logic              sign_big;
  logic              sign_small;
  logic              eff_sub;
  logic [EXP_W-1:0]  exp_max;
  logic [FRAC_W-1:0] frac_big;
  logic [FRAC_W-1:0] frac_small;
  logic              out_nan;
  logic              out_inf;

  // Drives operands and consumes results
  modport master (
    output in_valid, op_a, op_b, op_sub, out_ready,
    input  in_ready, out_valid, sign_big, sign_small, eff_sub,
           exp_max, frac_big, frac_small, out_nan, out_inf
  );

  // The alignment pipeline itself
  modport slave (
    input  in_valid, op_a, op_b, op_sub, out_ready,
    output in_ready, out_valid, sign_big, sign_small, eff_sub,
           exp_max, frac_big, frac_small, out_nan, out_inf
  );
endinterface

// File: rtl/fp_add_align_pipe.sv
// Two-stage alignment front end for the systolic-array FP adder.
// S1 orders the operands by magnitude and flags specials; S2 right-shifts
// the smaller significand with guard/round/sticky and drives the outputs.
module fp_add_align_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input logic                clk,
  input logic                nRST,
  fp_add_align_pipe_if.slave bus
);
  localparam int FP_W   = 1 + EXP_W + MAN_W;
  localparam int FRAC_W = MAN_W + 4;
  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  // ---------------- S1 compare logic ----------------
  logic             a_sign, b_sign, a_hid, b_hid, a_nan, b_nan, a_inf, b_inf, b_big;
  logic [EXP_W-1:0] a_exp, b_exp, a_eexp, b_eexp, big_exp, small_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic             nan_s1, inf_s1;

  assign a_sign = bus.op_a[FP_W-1];
  assign b_sign = bus.op_b[FP_W-1] ^ bus.op_sub;
  assign a_exp  = bus.op_a[FP_W-2 -: EXP_W];
  assign b_exp  = bus.op_b[FP_W-2 -: EXP_W];
  assign a_man  = bus.op_a[MAN_W-1:0];
  assign b_man  = bus.op_b[MAN_W-1:0];
  assign a_hid  = |a_exp;
  assign b_hid  = |b_exp;
  // Denormals share the exponent of the smallest normal
  assign a_eexp = a_hid ? a_exp : EXP_ONE;
  assign b_eexp = b_hid ? b_exp : EXP_ONE;
  assign a_nan  = (&a_exp) && (|a_man);
  assign b_nan  = (&b_exp) && (|b_man);
  assign a_inf  = (&a_exp) && !(|a_man);
  assign b_inf  = (&b_exp) && !(|b_man);
  // Strict compare: on equal magnitude A stays the big operand
  assign b_big     = {b_eexp, b_man} > {a_eexp, a_man};
  assign big_exp   = b_big ? b_eexp : a_eexp;
  assign small_exp = b_big ? a_eexp : b_eexp;
  // Opposite-signed infinities cancel to NaN
  assign nan_s1 = a_nan || b_nan || (a_inf && b_inf && (a_sign ^ b_sign));
  assign inf_s1 = (a_inf || b_inf) && !nan_s1;

  // ---------------- Handshake ----------------
  logic s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
  logic s1_en, s2_en, s1_load, s2_load;

  assign s2_en         = !out_valid_q || bus.out_ready;
  assign s1_en         = !s1_valid_q || s2_en;
  assign s1_load       = s1_en && bus.in_valid;
  assign s2_load       = s2_en && s1_valid_q;
  assign s1_valid_d    = s1_en ? bus.in_valid : s1_valid_q;
  assign out_valid_d   = s2_en ? s1_valid_q : out_valid_q;
  assign bus.in_ready  = s1_en;

  // Pipeline valid bits; cleared at once by reset so in-flight pairs vanish
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  // ---------------- S1 data registers ----------------
  logic              s1_sign_big_q, s1_sign_small_q, s1_nan_q, s1_inf_q;
  logic [EXP_W-1:0]  s1_exp_q, s1_diff_q;
  logic [FRAC_W-1:0] s1_frac_big_q, s1_frac_small_q;

  // Capture the ordered operand pair; held while S1 is stalled
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_sign_big_q   <= b_big ? b_sign : a_sign;
      s1_sign_small_q <= b_big ? a_sign : b_sign;
      s1_exp_q        <= big_exp;
      s1_diff_q       <= big_exp - small_exp;
      s1_frac_big_q   <= b_big ? {b_hid, b_man, 3'b000} : {a_hid, a_man, 3'b000};
      s1_frac_small_q <= b_big ? {a_hid, a_man, 3'b000} : {b_hid, b_man, 3'b000};
      s1_nan_q        <= nan_s1;
      s1_inf_q        <= inf_s1;
    end
  end

  // ---------------- S2 alignment shift ----------------
  logic [FRAC_W-1:0] shifted, lost_mask;
  logic [31:0]       diff_wide;
  logic              lost;

  assign diff_wide = {{(32-EXP_W){1'b0}}, s1_diff_q};

  // Right-shift with sticky; a shift past the field leaves only the sticky
  always_comb begin
    shifted   = {FRAC_W{1'b0}};
    lost_mask = {FRAC_W{1'b0}};
    lost      = 1'b0;
    if (diff_wide >= 32'(FRAC_W)) begin
      shifted = {{(FRAC_W-1){1'b0}}, |s1_frac_small_q};
    end else begin
      lost_mask  = ({{(FRAC_W-1){1'b0}}, 1'b1} << s1_diff_q) - {{(FRAC_W-1){1'b0}}, 1'b1};
      lost       = |(s1_frac_small_q & lost_mask);
      shifted    = s1_frac_small_q >> s1_diff_q;
      shifted[0] = shifted[0] | lost;
    end
  end

  logic              sign_big_q, sign_small_q, nan_q, inf_q;
  logic [EXP_W-1:0]  exp_max_q;
  logic [FRAC_W-1:0] frac_big_q, frac_small_q;

  // Output registers; zeroed by reset, held while the consumer stalls
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      nan_q        <= 1'b0;
      inf_q        <= 1'b0;
      exp_max_q    <= {EXP_W{1'b0}};
      frac_big_q   <= {FRAC_W{1'b0}};
      frac_small_q <= {FRAC_W{1'b0}};
    end else if (s2_load) begin
      sign_big_q   <= s1_sign_big_q;
      sign_small_q <= s1_sign_small_q;
      nan_q        <= s1_nan_q;
      inf_q        <= s1_inf_q;
      exp_max_q    <= s1_exp_q;
      frac_big_q   <= s1_frac_big_q;
      frac_small_q <= shifted;
    end else begin
      sign_big_q   <= sign_big_q;
      sign_small_q <= sign_small_q;
      nan_q        <= nan_q;
      inf_q        <= inf_q;
      exp_max_q    <= exp_max_q;
      frac_big_q   <= frac_big_q;
      frac_small_q <= frac_small_q;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.sign_big   = sign_big_q;
  assign bus.sign_small = sign_small_q;
  assign bus.eff_sub    = sign_big_q ^ sign_small_q;
  assign bus.exp_max    = exp_max_q;
  assign bus.frac_big   = frac_big_q;
  assign bus.frac_small = frac_small_q;
  assign bus.out_nan    = nan_q;
  assign bus.out_inf    = inf_q;
endmodule

// File: tb/tb_fp_add_align_pipe.sv
// Directed bench for fp_add_align_pipe (FP16 defaults).
module tb_fp_add_align_pipe;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;

  logic clk = 1'b0;
  logic nRST;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fp_add_align_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_add_align_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Send one pair with no backpressure; return on the negedge where it is visible
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.op_sub    = sub;
    bus.out_ready = 1'b1;
    #1 check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("latency_1cyc_no_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("latency_2cyc_valid", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic expect_res(input string tag, input logic sb, input logic ss, input logic [4:0] em,
                            input logic [13:0] fb, input logic [13:0] fs);
    check({tag, ".sign_big"},   32'(bus.sign_big),   32'(sb));
    check({tag, ".sign_small"}, 32'(bus.sign_small), 32'(ss));
    check({tag, ".eff_sub"},    32'(bus.eff_sub),    32'(sb ^ ss));
    check({tag, ".exp_max"},    32'(bus.exp_max),    32'(em));
    check({tag, ".frac_big"},   32'(bus.frac_big),   32'(fb));
    check({tag, ".frac_small"}, 32'(bus.frac_small), 32'(fs));
  endtask

  task automatic expect_flags(input string tag, input logic nan, input logic inf, input logic sb);
    check({tag, ".nan"},      32'(bus.out_nan),  32'(nan));
    check({tag, ".inf"},      32'(bus.out_inf),  32'(inf));
    check({tag, ".sign_big"}, 32'(bus.sign_big), 32'(sb));
  endtask

  // Absolute bound on run time
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Main stimulus sequence
  initial begin
    int idx;
    int nout;
    logic fire_in;
    logic fire_out;

    nRST          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = 16'h0000;
    bus.op_b      = 16'h0000;
    bus.op_sub    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.out_valid",  32'(bus.out_valid),  32'd0);
    check("rst.in_ready",   32'(bus.in_ready),   32'd1);
    check("rst.exp_max",    32'(bus.exp_max),    32'd0);
    check("rst.frac_big",   32'(bus.frac_big),   32'd0);
    check("rst.frac_small", 32'(bus.frac_small), 32'd0);
    check("rst.flags",      32'({bus.out_nan, bus.out_inf, bus.sign_big}), 32'd0);
    nRST = 1'b1;

    send(16'h3C00, 16'h4000, 1'b0); expect_res("t1_basic",      1'b0, 1'b0, 5'd16, 14'h2000, 14'h1000);
    send(16'h3C01, 16'h5000, 1'b0); expect_res("t2_sticky",     1'b0, 1'b0, 5'd20, 14'h2000, 14'h0101);
    send(16'h0001, 16'h7800, 1'b0); expect_res("t3_saturate",   1'b0, 1'b0, 5'd30, 14'h2000, 14'h0001);
    send(16'h3C00, 16'h3C00, 1'b1); expect_res("t4_tie_sub",    1'b0, 1'b1, 5'd15, 14'h2000, 14'h2000);
    send(16'h3C00, 16'h4000, 1'b1); expect_res("t_swap_sub",    1'b1, 1'b0, 5'd16, 14'h2000, 14'h1000);
    send(16'h3C00, 16'h6C00, 1'b0); expect_res("t_diff12",      1'b0, 1'b0, 5'd27, 14'h2000, 14'h0002);
    send(16'h0000, 16'h3C00, 1'b0); expect_res("t_zero_diff14", 1'b0, 1'b0, 5'd15, 14'h2000, 14'h0000);
    send(16'h0200, 16'h0001, 1'b0); expect_res("t_denorm_pair", 1'b0, 1'b0, 5'd1,  14'h1000, 14'h0008);
    send(16'h7E00, 16'h3C00, 1'b0); expect_flags("t5_nan_op",   1'b1, 1'b0, 1'b0);
    send(16'h7C00, 16'h7C00, 1'b1); expect_flags("t5_inf_sub",  1'b1, 1'b0, 1'b0);
    send(16'hFC00, 16'h4000, 1'b0); expect_flags("t5_neg_inf", 1'b0, 1'b1, 1'b1);
    check("t5_neg_inf.exp_max", 32'(bus.exp_max), 32'd31);
    send(16'h7C00, 16'h7C00, 1'b0); expect_flags("t_inf_add",   1'b0, 1'b1, 1'b0);

    // Backpressure: five pairs, consumer stalled for the first four cycles
    idx  = 0;
    nout = 0;
    for (int c = 0; c < 40 && nout < 5; c++) begin
      @(negedge clk);
      bus.out_ready = (c >= 4);
      bus.in_valid  = (idx < 5);
      bus.op_a      = 16'h3C00;
      bus.op_b      = 16'h4000 + 16'(idx) * 16'h0400;
      bus.op_sub    = 1'b0;
      #1;
      if (c == 2 || c == 3) begin
        check("bp.in_ready_low",  32'(bus.in_ready),   32'd0);
        check("bp.accepted",      32'(idx),            32'd2);
        check("bp.hold_valid",    32'(bus.out_valid),  32'd1);
        check("bp.hold_exp",      32'(bus.exp_max),    32'd16);
        check("bp.hold_frac",     32'(bus.frac_small), 32'h1000);
      end
      fire_in  = bus.in_valid && bus.in_ready;
      fire_out = bus.out_valid && bus.out_ready;
      if (fire_out) begin
        check("bp.order_exp",  32'(bus.exp_max),    32'd16 + 32'(nout));
        check("bp.order_frac", 32'(bus.frac_small), 32'h1000 >> nout);
        nout++;
      end
      @(posedge clk);
      if (fire_in) idx++;
    end
    check("bp.results_out", 32'(nout), 32'd5);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("bp.no_duplicate", 32'(bus.out_valid), 32'd0);

    // Reset while the pipe is full
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op_a      = 16'h3C00;
    bus.op_b      = 16'h4000;
    repeat (2) @(posedge clk);
    #2 nRST = 1'b0;
    #1;
    check("mid_rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst.exp_max",   32'(bus.exp_max),   32'd0);
    check("mid_rst.frac_big",  32'(bus.frac_big),  32'd0);
    check("mid_rst.in_ready",  32'(bus.in_ready),  32'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    nRST = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst.no_stale", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
